fp_soc_spi_slave: RTL and testbench
===================================

// Module: fp_soc_spi_slave
// PURPOSE
//  SPI slave (target) peripheral, the responder counterpart of the SoC SPI master. Register-mapped on the same 16-bit,
//  2-cycle-access CPU port. Mode 0 (CPOL=0, CPHA=0), 8-bit, MSB first. Oversamples SCLK/SS_n/MOSI in the clk domain.
//  Required ratio: f_SCLK <= f_clk/8. Holds one RX byte and one TX byte, with status flags and an interrupt.
// PARAMETERS
//  SYNC_STAGES   2      synchronizer flops on SCLK, SS_n and MOSI (minimum 2)
//  TX_IDLE_BYTE  8'hFF  byte shifted out when no TX byte is primed (underrun)
// PORTS
//  clk            in   1   system clock; all logic is on its rising edge
//  reset_n        in   1   asynchronous, active-low reset
//  spi_select     in   1   chip select for the CPU port
//  mem_addr       in   3   0 rxdata(r), 1 txdata(w), 2 status(r/w clr), 3 control(r/w), 6 eop value(r/w)
//  read_n         in   1   active-low read
//  write_n        in   1   active-low write
//  data_from_cpu  in   16  write data
//  data_to_cpu    out  16  registered read data
//  irq            out  1   registered interrupt
//  dataavailable  out  1   = RRDY
//  readyfordata   out  1   = TRDY
//  endofpacket    out  1   = EOP
//  SCLK           in   1   SPI clock from the master
//  SS_n           in   1   active-low slave select
//  MOSI           in   1   master-out data
//  MISO           out  1   slave-out data = tx_shift[7]
//  MISO_oe        out  1   1 while synchronized SS_n is low; pad is tristated otherwise
// BEHAVIOUR
//  - Reset values: all registers and flags 0; data_to_cpu = 0, irq = 0, MISO_oe = 0, tx_shift = 0.
//  - CPU port:
//      p1_rd = spi_select & ~read_n & ~rd_strobe (likewise for writes), so each access lasts 2 cycles.
//      Write side effects happen in cycle 2; data_to_cpu is registered and valid in cycle 2.
//  - Status word: {EOP[9], E=ROE|TOE[8], RRDY[7], TRDY[6], TMT[5], TOE[4], ROE[3], UR[2], 2'b0}.
//      TRDY = ~tx_primed.  TMT = ~tx_primed & ~active.
//      Any status write clears EOP, RRDY, ROE, TOE and UR.
//  - Control word: interrupt enables at the matching status bit positions (9, 8, 7, 6, 4, 3, 2).
//      irq <= OR of (flag & enable); 1-cycle latency.
//  - Synchronized SCLK and SS_n are edge-detected (delayed copy vs current).
//  - FSM IDLE -> ACTIVE on SS_n fall:
//      tx_shift <= tx_primed ? tx_hold : TX_IDLE_BYTE; tx_primed <= 0 on a load; UR <= 1 on an idle load.
//      bit_cnt <= 0.
//  - ACTIVE, SCLK rise:
//      rx_shift <= {rx_shift[6:0], MOSI_sync}; bit_cnt increments and wraps 7 -> 0.
//      On wrap (byte done): rx_hold <= received byte; RRDY <= 1; ROE <= 1 if RRDY was already 1.
//  - ACTIVE, SCLK fall:
//      bit_cnt == 0: load the next TX byte (same rule as SS_n fall).
//      Otherwise: tx_shift <= tx_shift << 1.
//  - ACTIVE -> IDLE on SS_n rise at any point:
//      Partial RX byte discarded (no RRDY, no flag); bit_cnt <= 0; MISO_oe <= 0.
//      Any TX byte already loaded into tx_shift is lost.
//  - Write to txdata: if TRDY, tx_hold <= data[7:0] and tx_primed <= 1; else TOE <= 1 and data is dropped.
//      Read of rxdata clears RRDY in cycle 2.
//  - Simultaneous events:
//      Byte-done with rxdata-read clear: RRDY stays 1 and no ROE.
//      Flag set with status-write clear: the set wins.
//      TX load with txdata write: shift gets the old tx_hold; the new byte primes tx_hold.
// CONFIGURATION
//  SPI_SLAVE_EOP_EN defined:
//      Adds a 16-bit eop value register at addr 6.
//      EOP <= 1 when a completed RX byte == eopval[7:0], or an accepted txdata write's data[7:0] == eopval[7:0].
//  SPI_SLAVE_EOP_EN undefined:
//      No eop register; addr 6 reads 0.
//      EOP, status bit 9 and endofpacket are tied 0; enable bit 9 is ignored.
// TESTING
//  1. Reset, then read status -> data_to_cpu = 16'h0060; irq = 0; MISO_oe = 0.
//  2. Write txdata 0xA5; master sends 0x3C at clk/10 -> MISO bits 1,0,1,0,0,1,0,1; rxdata = 0x003C;
//     status = 0x00E0 (RRDY, TRDY, TMT once SS_n is high); read rxdata -> RRDY = 0.
//  3. Master sends 0x11 then 0x22 with no CPU read, control = 0x0008 -> ROE = 1, rxdata = 0x22,
//     irq = 1 one clk after byte 2; status write -> ROE = 0, irq = 0 next clk.
//  4. No txdata written; master clocks 1 byte -> MISO shifts 0xFF; UR = 1 (status bit 2).
//  5. SS_n raised after 4 SCLKs, then full byte 0x5A -> RRDY stays 0 after the abort; rxdata = 0x5A afterwards.
//  6. EOP_EN: eopval = 0x0D, master sends 0x0D -> EOP = 1, endofpacket = 1.
//     Without EOP_EN: addr 6 reads 0 and EOP stays 0.

Source files
------------

// File: rtl/fp_soc_spi_slave.sv
// SPI mode-0 slave with a CPU register port: one RX byte, one TX byte, status flags and an interrupt.
// Define SPI_SLAVE_EOP_EN to add the end-of-packet value register (addr 6) and the EOP flag.
module fp_soc_spi_slave #(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [7:0] TX_IDLE_BYTE = 8'hFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        spi_select,
  input  logic [2:0]  mem_addr,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [15:0] data_from_cpu,
  output logic [15:0] data_to_cpu,
  output logic        irq,
  output logic        dataavailable,
  output logic        readyfordata,
  output logic        endofpacket,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_oe
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;
`ifdef SPI_SLAVE_EOP_EN
  localparam logic [15:0] CTRL_MASK = 16'h03DC;
`else
  localparam logic [15:0] CTRL_MASK = 16'h01DC;
`endif

  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
  logic sclk_dly_q, ss_dly_q;
  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise_s, sclk_fall_s, ss_rise_s, ss_fall_s;

  logic [0:0]  state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  rx_hold_q, rx_hold_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [7:0]  tx_hold_q, tx_hold_d;
  logic        tx_primed_q, tx_primed_d;
  logic        rrdy_q, rrdy_d, roe_q, roe_d, toe_q, toe_d, ur_q, ur_d;
  logic [15:0] ctrl_q, ctrl_d;
  logic        rd_strobe_q, rd_strobe_d, wr_strobe_q, wr_strobe_d;
  logic [15:0] data_to_cpu_q, data_to_cpu_d;
  logic        irq_q, irq_d;
  logic        miso_oe_q, miso_oe_d;

  logic        p1_rd_s, p1_wr_s, rd_rx_s, wr_tx_s, wr_status_s, wr_ctrl_s;
  logic        load_s, byte_done_s, tx_accept_s;
  logic [7:0]  rx_byte_s;
  logic        eop_s;
  logic [15:0] eopval_s, status_s, rd_mux_s;

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s        = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise_s = sclk_s & ~sclk_dly_q;
  assign sclk_fall_s = ~sclk_s & sclk_dly_q;
  assign ss_rise_s   = ss_s & ~ss_dly_q;
  assign ss_fall_s   = ~ss_s & ss_dly_q;

  // Each CPU access lasts two cycles; only the first cycle acts.
  assign p1_rd_s     = spi_select & ~read_n & ~rd_strobe_q;
  assign p1_wr_s     = spi_select & ~write_n & ~wr_strobe_q;
  assign rd_rx_s     = p1_rd_s & (mem_addr == 3'd0);
  assign wr_tx_s     = p1_wr_s & (mem_addr == 3'd1);
  assign wr_status_s = p1_wr_s & (mem_addr == 3'd2);
  assign wr_ctrl_s   = p1_wr_s & (mem_addr == 3'd3);
  assign rx_byte_s   = {rx_shift_q, mosi_s};
  assign tx_accept_s = wr_tx_s & (~tx_primed_q | load_s);

  assign status_s = {6'b000000, eop_s, roe_q | toe_q, rrdy_q, ~tx_primed_q,
                     ~tx_primed_q & (state_q == ST_IDLE), toe_q, roe_q, ur_q, 2'b00};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      ss_dly_q    <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      sclk_dly_q  <= sclk_s;
      ss_dly_q    <= ss_s;
    end
  end

  always_comb begin
    case (mem_addr)
      3'd0:    rd_mux_s = {8'h00, rx_hold_q};
      3'd2:    rd_mux_s = status_s;
      3'd3:    rd_mux_s = ctrl_q;
      3'd6:    rd_mux_s = eopval_s;
      default: rd_mux_s = 16'h0000;
    endcase
  end

  // Clears are applied before sets so that a coincident set wins.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    rx_hold_d     = rx_hold_q;
    tx_shift_d    = tx_shift_q;
    tx_hold_d     = tx_hold_q;
    tx_primed_d   = tx_primed_q;
    rrdy_d        = rrdy_q;
    roe_d         = roe_q;
    toe_d         = toe_q;
    ur_d          = ur_q;
    ctrl_d        = ctrl_q;
    miso_oe_d     = miso_oe_q;
    load_s        = 1'b0;
    byte_done_s   = 1'b0;
    rd_strobe_d   = p1_rd_s;
    wr_strobe_d   = p1_wr_s;
    data_to_cpu_d = p1_rd_s ? rd_mux_s : data_to_cpu_q;
    irq_d         = |(status_s & ctrl_q);

    if (wr_status_s) begin
      rrdy_d = 1'b0;
      roe_d  = 1'b0;
      toe_d  = 1'b0;
      ur_d   = 1'b0;
    end else begin
    end
    if (rd_rx_s) begin
      rrdy_d = 1'b0;
    end else begin
    end
    if (wr_ctrl_s) begin
      ctrl_d = data_from_cpu & CTRL_MASK;
    end else begin
    end

    case (state_q)
      ST_IDLE: begin
        if (ss_fall_s) begin
          state_d   = ST_ACTIVE;
          bit_cnt_d = 3'd0;
          miso_oe_d = 1'b1;
          load_s    = 1'b1;
        end else begin
        end
      end
      ST_ACTIVE: begin
        if (ss_rise_s) begin
          state_d   = ST_IDLE;
          bit_cnt_d = 3'd0;
          miso_oe_d = 1'b0;
        end else if (sclk_rise_s) begin
          rx_shift_d = rx_byte_s[6:0];
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_done_s = 1'b1;
            rx_hold_d   = rx_byte_s;
            rrdy_d      = 1'b1;
            if (rrdy_q && !rd_rx_s) begin
              roe_d = 1'b1;
            end else begin
            end
          end else begin
          end
        end else if (sclk_fall_s) begin
          if (bit_cnt_q == 3'd0) begin
            load_s = 1'b1;
          end else begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end else begin
        end
      end
      default: begin
        state_d   = ST_IDLE;
        miso_oe_d = 1'b0;
      end
    endcase

    if (load_s) begin
      tx_shift_d  = tx_primed_q ? tx_hold_q : TX_IDLE_BYTE;
      tx_primed_d = 1'b0;
      if (!tx_primed_q) begin
        ur_d = 1'b1;
      end else begin
      end
    end else begin
    end

    if (tx_accept_s) begin
      tx_hold_d   = data_from_cpu[7:0];
      tx_primed_d = 1'b1;
    end else if (wr_tx_s) begin
      toe_d = 1'b1;
    end else begin
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= 3'd0;
      rx_shift_q    <= 7'd0;
      rx_hold_q     <= 8'd0;
      tx_shift_q    <= 8'd0;
      tx_hold_q     <= 8'd0;
      tx_primed_q   <= 1'b0;
      rrdy_q        <= 1'b0;
      roe_q         <= 1'b0;
      toe_q         <= 1'b0;
      ur_q          <= 1'b0;
      ctrl_q        <= 16'h0000;
      rd_strobe_q   <= 1'b0;
      wr_strobe_q   <= 1'b0;
      data_to_cpu_q <= 16'h0000;
      irq_q         <= 1'b0;
      miso_oe_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      rx_hold_q     <= rx_hold_d;
      tx_shift_q    <= tx_shift_d;
      tx_hold_q     <= tx_hold_d;
      tx_primed_q   <= tx_primed_d;
      rrdy_q        <= rrdy_d;
      roe_q         <= roe_d;
      toe_q         <= toe_d;
      ur_q          <= ur_d;
      ctrl_q        <= ctrl_d;
      rd_strobe_q   <= rd_strobe_d;
      wr_strobe_q   <= wr_strobe_d;
      data_to_cpu_q <= data_to_cpu_d;
      irq_q         <= irq_d;
      miso_oe_q     <= miso_oe_d;
    end
  end

`ifdef SPI_SLAVE_EOP_EN
  logic        eop_q, eop_d;
  logic [15:0] eopval_q, eopval_d;

  // EOP fires on a matching received byte or a matching accepted TX byte.
  always_comb begin
    eop_d    = eop_q;
    eopval_d = eopval_q;
    if (p1_wr_s && (mem_addr == 3'd6)) begin
      eopval_d = data_from_cpu;
    end else begin
    end
    if (wr_status_s) begin
      eop_d = 1'b0;
    end else begin
    end
    if (byte_done_s && (rx_byte_s == eopval_q[7:0])) begin
      eop_d = 1'b1;
    end else if (tx_accept_s && (data_from_cpu[7:0] == eopval_q[7:0])) begin
      eop_d = 1'b1;
    end else begin
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eop_q    <= 1'b0;
      eopval_q <= 16'h0000;
    end else begin
      eop_q    <= eop_d;
      eopval_q <= eopval_d;
    end
  end

  assign eop_s    = eop_q;
  assign eopval_s = eopval_q;
`else
  assign eop_s    = 1'b0;
  assign eopval_s = 16'h0000;
`endif

  assign data_to_cpu   = data_to_cpu_q;
  assign irq           = irq_q;
  assign dataavailable = rrdy_q;
  assign readyfordata  = ~tx_primed_q;
  assign endofpacket   = eop_s;
  assign MISO          = tx_shift_q[7];
  assign MISO_oe       = miso_oe_q;

endmodule

// File: tb/tb_fp_soc_spi_slave.sv
// Directed bench for fp_soc_spi_slave: register-access vector table plus SPI transfer sequences.
module tb_fp_soc_spi_slave;

  localparam int HALF = 5;
`ifdef SPI_SLAVE_EOP_EN
  localparam logic [15:0] CTRL_MASK  = 16'h03DC;
  localparam logic [15:0] EOPV_EXP   = 16'h000D;
  localparam logic [15:0] EOP_OUT    = 16'h0001;
  localparam logic [15:0] EOP_STATUS = 16'h02E4;
`else
  localparam logic [15:0] CTRL_MASK  = 16'h01DC;
  localparam logic [15:0] EOPV_EXP   = 16'h0000;
  localparam logic [15:0] EOP_OUT    = 16'h0000;
  localparam logic [15:0] EOP_STATUS = 16'h00E4;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        spi_select = 1'b0;
  logic [2:0]  mem_addr = 3'd0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [15:0] data_from_cpu = 16'h0000;
  logic [15:0] data_to_cpu;
  logic        irq, dataavailable, readyfordata, endofpacket;
  logic        SCLK = 1'b0;
  logic        SS_n = 1'b1;
  logic        MOSI = 1'b0;
  logic        MISO, MISO_oe;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        is_wr;
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    logic        exp_irq;
  } vec_t;
  vec_t vecs[15];

  fp_soc_spi_slave dut (
    .clk(clk), .reset_n(reset_n), .spi_select(spi_select), .mem_addr(mem_addr),
    .read_n(read_n), .write_n(write_n), .data_from_cpu(data_from_cpu),
    .data_to_cpu(data_to_cpu), .irq(irq), .dataavailable(dataavailable),
    .readyfordata(readyfordata), .endofpacket(endofpacket),
    .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO), .MISO_oe(MISO_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cpu(input logic is_wr, input logic [2:0] a, input logic [15:0] d,
                     output logic [15:0] rd);
    @(negedge clk);
    spi_select = 1'b1; mem_addr = a; data_from_cpu = d;
    read_n = is_wr; write_n = ~is_wr;
    @(negedge clk);
    rd = data_to_cpu;
    @(negedge clk);
    spi_select = 1'b0; read_n = 1'b1; write_n = 1'b1;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [15:0] exp);
    logic [15:0] v;
    cpu(1'b0, a, 16'h0000, v);
    chk(name, v, exp);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    logic [15:0] v;
    cpu(1'b1, a, d, v);
  endtask

  // SS_n may rise while SCLK is still high so the trailing fall is not seen as a byte prefetch.
  task automatic spi_bit(input logic mb, input logic end_frame, output logic sb);
    MOSI = mb;
    repeat (HALF) @(negedge clk);
    sb = MISO;
    SCLK = 1'b1;
    repeat (HALF) @(negedge clk);
    if (end_frame) begin
      SS_n = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    SCLK = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b, input logic end_frame, output logic [7:0] cap);
    logic sb;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(b[i], end_frame && (i == 0), sb);
      cap[i] = sb;
    end
  endtask

  task automatic spi_begin();
    @(negedge clk);
    SS_n = 1'b0;
  endtask

  task automatic spi_settle();
    repeat (2 * HALF) @(negedge clk);
  endtask

  initial begin
    logic [7:0]  cap;
    logic [15:0] v;
    logic        sb;

    vecs[0]  = '{1'b0, 3'd2, 16'h0000, 16'h0060, 1'b0};
    vecs[1]  = '{1'b0, 3'd3, 16'h0000, 16'h0000, 1'b0};
    vecs[2]  = '{1'b0, 3'd6, 16'h0000, 16'h0000, 1'b0};
    vecs[3]  = '{1'b1, 3'd3, 16'hFFFF, 16'h0000, 1'b1};
    vecs[4]  = '{1'b0, 3'd3, 16'h0000, CTRL_MASK, 1'b1};
    vecs[5]  = '{1'b1, 3'd1, 16'h0012, 16'h0000, 1'b0};
    vecs[6]  = '{1'b0, 3'd2, 16'h0000, 16'h0000, 1'b0};
    vecs[7]  = '{1'b1, 3'd1, 16'h0034, 16'h0000, 1'b1};
    vecs[8]  = '{1'b0, 3'd2, 16'h0000, 16'h0110, 1'b1};
    vecs[9]  = '{1'b1, 3'd2, 16'hFFFF, 16'h0000, 1'b0};
    vecs[10] = '{1'b0, 3'd2, 16'h0000, 16'h0000, 1'b0};
    vecs[11] = '{1'b1, 3'd3, 16'h0000, 16'h0000, 1'b0};
    vecs[12] = '{1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0};
    vecs[13] = '{1'b0, 3'd1, 16'h0000, 16'h0000, 1'b0};
    vecs[14] = '{1'b0, 3'd7, 16'h0000, 16'h0000, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset data_to_cpu", data_to_cpu, 16'h0000);
    chk("reset irq", {15'd0, irq}, 16'h0000);
    chk("reset MISO_oe", {15'd0, MISO_oe}, 16'h0000);
    chk("reset MISO", {15'd0, MISO}, 16'h0000);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      cpu(vecs[i].is_wr, vecs[i].addr, vecs[i].wdata, v);
      if (!vecs[i].is_wr) chk($sformatf("vec%0d rdata", i), v, vecs[i].exp_rd);
      chk($sformatf("vec%0d irq", i), {15'd0, irq}, {15'd0, vecs[i].exp_irq});
    end

    // Fresh reset so the TX byte primed by the table does not leak into the transfers.
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    rd_chk("t1 status", 3'd2, 16'h0060);
    chk("t1 irq", {15'd0, irq}, 16'h0000);
    chk("t1 MISO_oe", {15'd0, MISO_oe}, 16'h0000);

    wr(3'd1, 16'h00A5);
    spi_begin();
    repeat (4) @(negedge clk);
    chk("t2 MISO_oe active", {15'd0, MISO_oe}, 16'h0001);
    spi_byte(8'h3C, 1'b1, cap);
    spi_settle();
    chk("t2 MISO bits", {8'h00, cap}, 16'h00A5);
    chk("t2 MISO_oe idle", {15'd0, MISO_oe}, 16'h0000);
    chk("t2 dataavailable", {15'd0, dataavailable}, 16'h0001);
    chk("t2 readyfordata", {15'd0, readyfordata}, 16'h0001);
    rd_chk("t2 status", 3'd2, 16'h00E0);
    rd_chk("t2 rxdata", 3'd0, 16'h003C);
    rd_chk("t2 status after read", 3'd2, 16'h0060);

    wr(3'd3, 16'h0008);
    spi_begin();
    spi_byte(8'h11, 1'b0, cap);
    chk("t3 irq after byte1", {15'd0, irq}, 16'h0000);
    spi_byte(8'h22, 1'b1, cap);
    chk("t3 irq after byte2", {15'd0, irq}, 16'h0001);
    spi_settle();
    rd_chk("t3 status", 3'd2, 16'h01EC);
    rd_chk("t3 rxdata", 3'd0, 16'h0022);
    wr(3'd2, 16'h0000);
    chk("t3 irq after clear", {15'd0, irq}, 16'h0000);
    rd_chk("t3 status cleared", 3'd2, 16'h0060);

    wr(3'd3, 16'h0000);
    spi_begin();
    spi_byte(8'h00, 1'b1, cap);
    spi_settle();
    chk("t4 MISO idle byte", {8'h00, cap}, 16'h00FF);
    rd_chk("t4 status", 3'd2, 16'h00E4);
    rd_chk("t4 rxdata", 3'd0, 16'h0000);
    wr(3'd2, 16'h0000);

    spi_begin();
    for (int i = 7; i >= 4; i--) spi_bit(1'b1, 1'b0, sb);
    repeat (HALF) @(negedge clk);
    SS_n = 1'b1;
    spi_settle();
    rd_chk("t5 status after abort", 3'd2, 16'h0064);
    chk("t5 dataavailable after abort", {15'd0, dataavailable}, 16'h0000);
    spi_begin();
    spi_byte(8'h5A, 1'b1, cap);
    spi_settle();
    rd_chk("t5 status full byte", 3'd2, 16'h00E4);
    rd_chk("t5 rxdata", 3'd0, 16'h005A);

    wr(3'd2, 16'h0000);
    wr(3'd6, 16'h000D);
    rd_chk("t6 eopval", 3'd6, EOPV_EXP);
    chk("t6 endofpacket before", {15'd0, endofpacket}, 16'h0000);
    spi_begin();
    spi_byte(8'h0D, 1'b1, cap);
    spi_settle();
    chk("t6 endofpacket", {15'd0, endofpacket}, EOP_OUT);
    rd_chk("t6 status", 3'd2, EOP_STATUS);
    rd_chk("t6 rxdata", 3'd0, 16'h000D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
